// File: rtl/data_memory_bytelane_if.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_bytelane_if
// Purpose  : Request/response bundle between a MEM-stage master and the
//            byte-lane data memory.
// Revision : 1.0
// ============================================================================
interface data_memory_bytelane_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
);
  logic              En;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic              memRead;
  logic              memWrite;
  logic [1:0]        memSize;
  logic              memUnsigned;
  logic [DATA_W-1:0] read_data;
  logic              rd_valid;
  logic              misaligned;
  logic              out_of_range;
  logic              busy;

  modport master (
    output En, address, write_data, memRead, memWrite, memSize, memUnsigned,
    input  read_data, rd_valid, misaligned, out_of_range, busy
  );

  modport slave (
    input  En, address, write_data, memRead, memWrite, memSize, memUnsigned,
    output read_data, rd_valid, misaligned, out_of_range, busy
  );
endinterface
`default_nettype wire

// File: rtl/data_memory_bytelane.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_bytelane
// Purpose  : Byte-addressed data memory with sized, extended loads/stores,
//            registered read, error pulses and an optional post-reset clear.
// Revision : 1.0
// ============================================================================
module data_memory_bytelane #(
  parameter int DATA_W         = 64,
  parameter int DEPTH          = 64,
  parameter int ADDR_W         = 64,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  Clk,
  input  logic                  Rst,
  data_memory_bytelane_if.slave bus
);

  localparam int c_BYTES = DATA_W / 8;
  localparam int c_OFF_W = $clog2(c_BYTES);
  localparam int c_IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0]  c_LIMIT = ADDR_W'(DEPTH * c_BYTES);
  localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  localparam state_e c_RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

  logic [DATA_W-1:0]  mem_q [DEPTH];

  state_e             state_q, state_d;
  logic [c_IDX_W-1:0] ptr_q, ptr_d;
  logic               clr_we;

  logic [DATA_W-1:0]  read_data_q;
  logic               rd_valid_q;
  logic               misaligned_q;
  logic               out_of_range_q;

  logic               w_busy;
  logic               w_accept;
  logic [3:0]         w_nbytes;
  logic [2:0]         w_align_mask;
  logic               w_size_bad;
  logic               w_mis;
  logic               w_oor;
  logic               w_err;
  logic               w_do_write;
  logic               w_do_read;
  logic [c_IDX_W-1:0] w_idx;
  logic [c_OFF_W-1:0] w_lane;
  logic [DATA_W-1:0]  w_cur;
  logic [DATA_W-1:0]  w_shift_data;
  logic [DATA_W-1:0]  w_merged;
  logic [DATA_W-1:0]  w_src;
  logic [DATA_W-1:0]  w_field;
  logic               w_sign_bit;
  logic [DATA_W-1:0]  w_ext;

  // --------------------------------------------------------------------------
  // Clear sequencer: held in its reset state while Rst is high, so busy is
  // already asserted on the first cycle after Rst falls.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= c_RST_STATE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_we  = 1'b0;
    case (state_q)
      S_CLEAR: begin
        clr_we = 1'b1;
        ptr_d  = ptr_q + c_IDX_W'(1);
        if (ptr_q == c_LAST) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign w_busy = (state_q == S_CLEAR);

  // --------------------------------------------------------------------------
  // Access decode and error classification
  // --------------------------------------------------------------------------
  always_comb begin
    w_nbytes     = 4'd1;
    w_align_mask = 3'b000;
    case (bus.memSize)
      2'b00: begin w_nbytes = 4'd1; w_align_mask = 3'b000; end
      2'b01: begin w_nbytes = 4'd2; w_align_mask = 3'b001; end
      2'b10: begin w_nbytes = 4'd4; w_align_mask = 3'b011; end
      default: begin w_nbytes = 4'd8; w_align_mask = 3'b111; end
    endcase
  end

  assign w_accept   = !Rst && bus.En && !w_busy && (bus.memRead || bus.memWrite);
  assign w_size_bad = (c_BYTES < 8) && (bus.memSize == 2'b11);
  assign w_mis      = w_size_bad || ((bus.address[2:0] & w_align_mask) != 3'b000);
  assign w_oor      = (bus.address >= c_LIMIT);
  assign w_err      = w_mis || w_oor;
  assign w_do_write = w_accept && bus.memWrite && !w_err;
  assign w_do_read  = w_accept && bus.memRead  && !w_err;

  assign w_idx  = bus.address[c_OFF_W +: c_IDX_W];
  assign w_lane = bus.address[c_OFF_W-1:0];
  assign w_cur  = mem_q[w_idx];

  // --------------------------------------------------------------------------
  // Store merge; a combined read+write sees the merged word (write-first).
  // --------------------------------------------------------------------------
  always_comb begin
    w_shift_data = bus.write_data << {w_lane, 3'b000};
    w_merged     = w_cur;
    for (int b = 0; b < c_BYTES; b++) begin
      if ((b >= int'(w_lane)) && (b < int'(w_lane) + int'(w_nbytes))) begin
        w_merged[8*b +: 8] = w_shift_data[8*b +: 8];
      end
    end
  end

  assign w_src   = bus.memWrite ? w_merged : w_cur;
  assign w_field = w_src >> {w_lane, 3'b000};

  always_comb begin
    case (bus.memSize)
      2'b00:   w_sign_bit = w_field[7];
      2'b01:   w_sign_bit = w_field[15];
      2'b10:   w_sign_bit = w_field[31];
      default: w_sign_bit = w_field[DATA_W-1];
    endcase
    if (bus.memUnsigned) begin
      w_sign_bit = 1'b0;
    end
    w_ext = '0;
    for (int i = 0; i < DATA_W; i++) begin
      w_ext[i] = (i < 8 * int'(w_nbytes)) ? w_field[i] : w_sign_bit;
    end
  end

  // --------------------------------------------------------------------------
  // Storage array; the clear and a store can never collide because stores
  // are only accepted when the sequencer is idle.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (clr_we && !Rst) begin
      mem_q[ptr_q] <= '0;
    end else if (w_do_write) begin
      mem_q[w_idx] <= w_merged;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      read_data_q    <= '0;
      rd_valid_q     <= 1'b0;
      misaligned_q   <= 1'b0;
      out_of_range_q <= 1'b0;
    end else begin
      rd_valid_q     <= w_do_read;
      misaligned_q   <= w_accept && w_mis;
      out_of_range_q <= w_accept && !w_mis && w_oor;
      if (w_do_read) begin
        read_data_q <= w_ext;
      end
    end
  end

  assign bus.read_data    = read_data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.misaligned   = misaligned_q;
  assign bus.out_of_range = out_of_range_q;
  assign bus.busy         = w_busy;

endmodule
`default_nettype wire
